// File: rtl/ceespu_pkg.sv
// Shared types and constants for the ceespu ALU scheduler slice.
// Holds the ALU opcode encodings, the scheduler FSM state type and the
// requester port-id type.
package ceespu_pkg;

    localparam int unsigned DataW  = 32;
    localparam int unsigned AluopW = 4;

    typedef logic [AluopW-1:0] aluop_t;
    typedef logic [DataW-1:0]  data_t;

    // ALU opcode encodings
    localparam aluop_t AluopAdd    = 4'd0;
    localparam aluop_t AluopOr     = 4'd1;
    localparam aluop_t AluopAnd    = 4'd2;
    localparam aluop_t AluopXor    = 4'd3;
    localparam aluop_t AluopSext8  = 4'd4;
    localparam aluop_t AluopSext16 = 4'd5;
    localparam aluop_t AluopShl    = 4'd6;
    localparam aluop_t AluopShr    = 4'd7;
    localparam aluop_t AluopSar    = 4'd8;
    localparam aluop_t AluopMul    = 4'd9;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StMulWait,
        StResp
    } sched_state_e;

    // 0 = core execute stage, 1 = auxiliary requester
    typedef logic port_id_t;

    // The multiply is the only operation whose result arrives late.
    function automatic logic is_mul(input aluop_t op);
        return op == AluopMul;
    endfunction

endpackage

// File: rtl/ceespu_rr_arb2.sv
// Two-way arbiter with a priority pointer.
// Option: CEESPU_ALU_SCHED_RR_EN selects round-robin; otherwise port 0 has
// fixed priority and the pointer stays at 0.
module ceespu_rr_arb2
    import ceespu_pkg::*;
(
    input  logic       I_clk,
    input  logic       I_rst,
    input  logic [1:0] valid_i,
    input  logic       accept_i,
    output logic [1:0] grant_o,
    output port_id_t   ptr_o
);

    port_id_t ptr_d, ptr_q;

    // Grant: a lone requester always wins, a tie goes to the pointed port.
    always_comb begin
        grant_o = valid_i;
        if (&valid_i) begin
            grant_o = ptr_q ? 2'b10 : 2'b01;
        end
    end

    // Pointer update on an accepted grant.
    always_comb begin
        ptr_d = ptr_q;
`ifdef CEESPU_ALU_SCHED_RR_EN
        // Move the pointer to the port that just lost (or did not ask).
        if (accept_i) begin
            ptr_d = grant_o[0];
        end
`else
        // Fixed priority: the pointer is pinned to port 0.
        if (accept_i) begin
            ptr_d = 1'b0;
        end
`endif
    end

    // Pointer register.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/ceespu_alu_sched.sv
// Two-port scheduler sharing the single ceespu ALU between the core execute
// stage (port 0) and an auxiliary requester (port 1). One operation in flight;
// operands are held for the pipelined multiply; each result returns to the
// port that issued it.
// Option: CEESPU_ALU_SCHED_RR_EN enables round-robin arbitration (in the
// arbiter sub-module); default is fixed priority to port 0.
module ceespu_alu_sched
    import ceespu_pkg::*;
(
    input  logic        I_clk,
    input  logic        I_rst,

    input  logic        I_req0_valid,
    input  logic [3:0]  I_req0_aluop,
    input  logic [31:0] I_req0_dataA,
    input  logic [31:0] I_req0_dataB,
    input  logic        I_req0_Cin,
    output logic        O_req0_ready,

    input  logic        I_req1_valid,
    input  logic [3:0]  I_req1_aluop,
    input  logic [31:0] I_req1_dataA,
    input  logic [31:0] I_req1_dataB,
    input  logic        I_req1_Cin,
    output logic        O_req1_ready,

    output logic        O_resp0_valid,
    input  logic        I_resp0_ready,
    output logic [31:0] O_resp0_data,
    output logic        O_resp0_Cout,

    output logic        O_resp1_valid,
    input  logic        I_resp1_ready,
    output logic [31:0] O_resp1_data,
    output logic        O_resp1_Cout,

    output logic [31:0] O_alu_dataA,
    output logic [31:0] O_alu_dataB,
    output logic        O_alu_Cin,
    output logic [3:0]  O_alu_aluop,
    input  logic [31:0] I_alu_dataResult,
    input  logic        I_alu_Cout,
    input  logic        I_alu_dataReady,

    output logic        O_busy
);

    sched_state_e state_d, state_q;

    aluop_t   hold_aluop_d, hold_aluop_q;
    data_t    hold_a_d, hold_a_q;
    data_t    hold_b_d, hold_b_q;
    logic     hold_cin_d, hold_cin_q;
    port_id_t hold_port_d, hold_port_q;

    data_t    resp_data_d, resp_data_q;
    logic     resp_cout_d, resp_cout_q;

    logic [1:0] grant;
    port_id_t   ptr;
    logic       in_idle;
    logic       accept;
    logic       resp_fire;
    logic       alu_drive;

    assign in_idle = (state_q == StIdle);
    // Reset blocks the handshake in the same cycle so nothing is latched.
    assign accept  = in_idle & (|grant) & ~I_rst;

    ceespu_rr_arb2 u_arb (
        .I_clk    (I_clk),
        .I_rst    (I_rst),
        .valid_i  ({I_req1_valid, I_req0_valid}),
        .accept_i (accept),
        .grant_o  (grant),
        .ptr_o    (ptr)
    );

    // Request-side handshake outputs: only the granted port, only in IDLE.
    always_comb begin
        O_req0_ready = in_idle & grant[0] & ~I_rst;
        O_req1_ready = in_idle & grant[1] & ~I_rst;
    end

    // Response consumption by whichever port owns the in-flight result.
    assign resp_fire = hold_port_q ? I_resp1_ready : I_resp0_ready;

    // Next-state, hold-register capture and response capture.
    always_comb begin
        state_d      = state_q;
        hold_aluop_d = hold_aluop_q;
        hold_a_d     = hold_a_q;
        hold_b_d     = hold_b_q;
        hold_cin_d   = hold_cin_q;
        hold_port_d  = hold_port_q;
        resp_data_d  = resp_data_q;
        resp_cout_d  = resp_cout_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    hold_port_d  = grant[1];
                    hold_aluop_d = grant[1] ? I_req1_aluop : I_req0_aluop;
                    hold_a_d     = grant[1] ? I_req1_dataA : I_req0_dataA;
                    hold_b_d     = grant[1] ? I_req1_dataB : I_req0_dataB;
                    hold_cin_d   = grant[1] ? I_req1_Cin   : I_req0_Cin;
                    state_d      = StExec;
                end
            end
            StExec: begin
                if (is_mul(hold_aluop_q)) begin
                    state_d = StMulWait;
                end else begin
                    resp_data_d = I_alu_dataResult;
                    resp_cout_d = I_alu_Cout;
                    state_d     = StResp;
                end
            end
            StMulWait: begin
                // No timeout: the ALU is trusted to finish eventually.
                if (I_alu_dataReady) begin
                    resp_data_d = I_alu_dataResult;
                    resp_cout_d = 1'b0;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (resp_fire) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, hold and response registers with synchronous reset.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q      <= StIdle;
            hold_aluop_q <= AluopAdd;
            hold_a_q     <= '0;
            hold_b_q     <= '0;
            hold_cin_q   <= 1'b0;
            hold_port_q  <= 1'b0;
            resp_data_q  <= '0;
            resp_cout_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_aluop_q <= hold_aluop_d;
            hold_a_q     <= hold_a_d;
            hold_b_q     <= hold_b_d;
            hold_cin_q   <= hold_cin_d;
            hold_port_q  <= hold_port_d;
            resp_data_q  <= resp_data_d;
            resp_cout_q  <= resp_cout_d;
        end
    end

    // ALU drive: held operands while executing, an idle ADD of zeros
    // otherwise so the ALU's multi-cycle sequencing stays quiet.
    always_comb begin
        alu_drive   = (state_q == StExec) | (state_q == StMulWait);
        O_alu_aluop = alu_drive ? hold_aluop_q : AluopAdd;
        O_alu_dataA = alu_drive ? hold_a_q : '0;
        O_alu_dataB = alu_drive ? hold_b_q : '0;
        O_alu_Cin   = alu_drive & hold_cin_q;
    end

    // Response outputs: valid only toward the issuing port.
    always_comb begin
        O_resp0_valid = (state_q == StResp) & (hold_port_q == 1'b0) & ~I_rst;
        O_resp1_valid = (state_q == StResp) & (hold_port_q == 1'b1) & ~I_rst;
        O_resp0_data  = resp_data_q;
        O_resp1_data  = resp_data_q;
        O_resp0_Cout  = resp_cout_q;
        O_resp1_Cout  = resp_cout_q;
        O_busy        = ~in_idle;
    end

    // The pointer is consumed inside the arbiter; exposed here for debug taps.
    logic unused_ptr;
    assign unused_ptr = ptr;

endmodule

// File: tb/tb_ceespu_alu_sched.sv
// Directed self-checking bench for ceespu_alu_sched with a small ALU model
// (combinational ops, multiply result on the third multiply cycle).
module tb_ceespu_alu_sched;

    logic        I_clk;
    logic        I_rst;
    logic        I_req0_valid, I_req1_valid;
    logic [3:0]  I_req0_aluop, I_req1_aluop;
    logic [31:0] I_req0_dataA, I_req0_dataB, I_req1_dataA, I_req1_dataB;
    logic        I_req0_Cin, I_req1_Cin;
    logic        O_req0_ready, O_req1_ready;
    logic        O_resp0_valid, O_resp1_valid;
    logic        I_resp0_ready, I_resp1_ready;
    logic [31:0] O_resp0_data, O_resp1_data;
    logic        O_resp0_Cout, O_resp1_Cout;
    logic [31:0] O_alu_dataA, O_alu_dataB;
    logic        O_alu_Cin;
    logic [3:0]  O_alu_aluop;
    logic [31:0] I_alu_dataResult;
    logic        I_alu_Cout;
    logic        I_alu_dataReady;
    logic        O_busy;

    int n_checks = 0;
    int n_errors = 0;
    int mul_cnt;

    ceespu_alu_sched dut (
        .I_clk            (I_clk),
        .I_rst            (I_rst),
        .I_req0_valid     (I_req0_valid),
        .I_req0_aluop     (I_req0_aluop),
        .I_req0_dataA     (I_req0_dataA),
        .I_req0_dataB     (I_req0_dataB),
        .I_req0_Cin       (I_req0_Cin),
        .O_req0_ready     (O_req0_ready),
        .I_req1_valid     (I_req1_valid),
        .I_req1_aluop     (I_req1_aluop),
        .I_req1_dataA     (I_req1_dataA),
        .I_req1_dataB     (I_req1_dataB),
        .I_req1_Cin       (I_req1_Cin),
        .O_req1_ready     (O_req1_ready),
        .O_resp0_valid    (O_resp0_valid),
        .I_resp0_ready    (I_resp0_ready),
        .O_resp0_data     (O_resp0_data),
        .O_resp0_Cout     (O_resp0_Cout),
        .O_resp1_valid    (O_resp1_valid),
        .I_resp1_ready    (I_resp1_ready),
        .O_resp1_data     (O_resp1_data),
        .O_resp1_Cout     (O_resp1_Cout),
        .O_alu_dataA      (O_alu_dataA),
        .O_alu_dataB      (O_alu_dataB),
        .O_alu_Cin        (O_alu_Cin),
        .O_alu_aluop      (O_alu_aluop),
        .I_alu_dataResult (I_alu_dataResult),
        .I_alu_Cout       (I_alu_Cout),
        .I_alu_dataReady  (I_alu_dataReady),
        .O_busy           (O_busy)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    // ALU model; multiply drives a junk Cout of 1 so the forced 0 is visible.
    always_comb begin
        I_alu_dataResult = '0;
        I_alu_Cout       = 1'b0;
        I_alu_dataReady  = 1'b0;
        case (O_alu_aluop)
            4'd0: {I_alu_Cout, I_alu_dataResult} = {1'b0, O_alu_dataA} + {1'b0, O_alu_dataB}
                                                   + {32'd0, O_alu_Cin};
            4'd1: I_alu_dataResult = O_alu_dataA | O_alu_dataB;
            4'd2: I_alu_dataResult = O_alu_dataA & O_alu_dataB;
            4'd3: I_alu_dataResult = O_alu_dataA ^ O_alu_dataB;
            4'd9: begin
                I_alu_dataResult = O_alu_dataA * O_alu_dataB;
                I_alu_Cout       = 1'b1;
                I_alu_dataReady  = (mul_cnt == 2);
            end
            default: I_alu_dataResult = '0;
        endcase
    end

    // Counts consecutive cycles the ALU sees a multiply.
    always_ff @(posedge I_clk) begin
        mul_cnt <= (O_alu_aluop == 4'd9) ? mul_cnt + 1 : 0;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge I_clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic c);
        I_req0_valid = v; I_req0_aluop = op; I_req0_dataA = a; I_req0_dataB = b; I_req0_Cin = c;
    endtask

    task automatic drive1(input logic v, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic c);
        I_req1_valid = v; I_req1_aluop = op; I_req1_dataA = a; I_req1_dataB = b; I_req1_Cin = c;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [31:0] exp_g;

        I_rst = 1'b1;
        drive0(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        drive1(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        I_resp0_ready = 1'b1;
        I_resp1_ready = 1'b1;
        tick(); tick();
        #1;
        check_eq("rst_busy", {31'd0, O_busy}, 32'd0);
        check_eq("rst_resp_valid", {30'd0, O_resp1_valid, O_resp0_valid}, 32'd0);
        check_eq("rst_alu_a", O_alu_dataA, 32'd0);
        check_eq("rst_alu_op", {28'd0, O_alu_aluop}, 32'd0);
        tick();
        I_rst = 1'b0;

        // Port 0 OR
        tick();
        drive0(1'b1, 4'd1, 32'h0000F0F0, 32'h00000F0F, 1'b0);
        #1;
        check_eq("or_ready0", {30'd0, O_req1_ready, O_req0_ready}, 32'd1);
        tick();
        I_req0_valid = 1'b0;
        #1;
        check_eq("or_exec_busy", {31'd0, O_busy}, 32'd1);
        check_eq("or_exec_nores", {31'd0, O_resp0_valid}, 32'd0);
        check_eq("or_alu_op", {28'd0, O_alu_aluop}, 32'd1);
        check_eq("or_alu_a", O_alu_dataA, 32'h0000F0F0);
        tick(); #1;
        check_eq("or_resp_valid", {30'd0, O_resp1_valid, O_resp0_valid}, 32'd1);
        check_eq("or_resp_data", O_resp0_data, 32'h0000FFFF);
        check_eq("or_resp_cout", {31'd0, O_resp0_Cout}, 32'd0);
        tick(); #1;
        check_eq("or_idle", {31'd0, O_busy}, 32'd0);

        // Port 1 ADD with carry out
        tick();
        drive1(1'b1, 4'd0, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        #1;
        check_eq("add_ready1", {30'd0, O_req1_ready, O_req0_ready}, 32'd2);
        tick();
        I_req1_valid = 1'b0;
        tick(); #1;
        check_eq("add_resp_valid", {30'd0, O_resp1_valid, O_resp0_valid}, 32'd2);
        check_eq("add_resp_data", O_resp1_data, 32'h00000000);
        check_eq("add_resp_cout", {31'd0, O_resp1_Cout}, 32'd1);
        tick(); #1;
        check_eq("add_idle", {31'd0, O_busy}, 32'd0);

        // Port 0 MUL with port 1 knocking during the window
        tick();
        drive0(1'b1, 4'd9, 32'd7, 32'd6, 1'b0);
        #1;
        check_eq("mul_ready0", {31'd0, O_req0_ready}, 32'd1);
        tick();
        I_req0_valid = 1'b0;
        drive1(1'b1, 4'd3, 32'hFF00FF00, 32'h0F0F0F0F, 1'b0);
        #1;
        check_eq("mul_t1_ready1", {31'd0, O_req1_ready}, 32'd0);
        check_eq("mul_t1_op", {28'd0, O_alu_aluop}, 32'd9);
        check_eq("mul_t1_a", O_alu_dataA, 32'd7);
        for (int k = 2; k <= 3; k++) begin
            tick(); #1;
            check_eq("mul_hold_ready1", {31'd0, O_req1_ready}, 32'd0);
            check_eq("mul_hold_b", O_alu_dataB, 32'd6);
            check_eq("mul_hold_op", {28'd0, O_alu_aluop}, 32'd9);
            check_eq("mul_hold_nores", {31'd0, O_resp0_valid}, 32'd0);
        end
        tick(); #1;
        check_eq("mul_resp_valid", {31'd0, O_resp0_valid}, 32'd1);
        check_eq("mul_resp_data", O_resp0_data, 32'd42);
        check_eq("mul_resp_cout", {31'd0, O_resp0_Cout}, 32'd0);
        check_eq("mul_resp_ready1", {31'd0, O_req1_ready}, 32'd0);
        tick(); #1;
        check_eq("xor_ready1", {31'd0, O_req1_ready}, 32'd1);
        tick();
        I_req1_valid = 1'b0;
        tick(); #1;
        check_eq("xor_resp_valid", {30'd0, O_resp1_valid, O_resp0_valid}, 32'd2);
        check_eq("xor_resp_data", O_resp1_data, 32'hF00FF00F);
        tick(); #1;
        check_eq("xor_idle", {31'd0, O_busy}, 32'd0);

        // Both ports valid continuously
        tick();
        drive0(1'b1, 4'd0, 32'd10, 32'd1, 1'b0);
        drive1(1'b1, 4'd0, 32'd20, 32'd2, 1'b0);
        #1;
        for (int i = 0; i < 4; i++) begin
            c = 0;
            while (!(O_req0_ready || O_req1_ready) && c < 8) begin
                tick(); #1;
                c++;
            end
`ifdef CEESPU_ALU_SCHED_RR_EN
            exp_g = (i % 2 == 1) ? 32'd2 : 32'd1;
`else
            exp_g = 32'd1;
`endif
            check_eq("arb_timeout", {31'd0, c < 8}, 32'd1);
            check_eq("arb_grant", {30'd0, O_req1_ready, O_req0_ready}, exp_g);
            tick(); #1;
        end
        drive0(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        drive1(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        c = 0;
        while (O_busy && c < 10) begin
            tick(); #1;
            c++;
        end
        check_eq("arb_drain", {31'd0, O_busy}, 32'd0);

        // Response back-pressure on port 0
        tick();
        I_resp0_ready = 1'b0;
        drive0(1'b1, 4'd0, 32'd5, 32'd3, 1'b1);
        #1;
        check_eq("bp_ready0", {31'd0, O_req0_ready}, 32'd1);
        tick();
        I_req0_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 0) drive1(1'b1, 4'd1, 32'd1, 32'd2, 1'b0);
            #1;
            check_eq("bp_valid", {31'd0, O_resp0_valid}, 32'd1);
            check_eq("bp_data", O_resp0_data, 32'd9);
            check_eq("bp_no_grant", {31'd0, O_req1_ready}, 32'd0);
        end
        I_resp0_ready = 1'b1;
        tick(); #1;
        check_eq("bp_idle", {31'd0, O_busy}, 32'd0);
        check_eq("bp_resp_gone", {31'd0, O_resp0_valid}, 32'd0);
        check_eq("bp_ready1_after", {31'd0, O_req1_ready}, 32'd1);
        I_req1_valid = 1'b0;

        // Reset during MUL_WAIT
        tick();
        drive0(1'b1, 4'd9, 32'd3, 32'd5, 1'b0);
        #1;
        check_eq("rmul_ready0", {31'd0, O_req0_ready}, 32'd1);
        tick();
        I_req0_valid = 1'b0;
        tick(); #1;
        check_eq("rmul_busy", {31'd0, O_busy}, 32'd1);
        I_rst = 1'b1;
        tick();
        I_rst = 1'b0;
        #1;
        check_eq("rmul_idle", {31'd0, O_busy}, 32'd0);
        check_eq("rmul_ready", {30'd0, O_req1_ready, O_req0_ready}, 32'd0);
        check_eq("rmul_alu_op", {28'd0, O_alu_aluop}, 32'd0);
        check_eq("rmul_alu_a", O_alu_dataA, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            check_eq("rmul_no_resp", {30'd0, O_resp1_valid, O_resp0_valid}, 32'd0);
        end
        tick();
        drive0(1'b1, 4'd0, 32'd2, 32'd3, 1'b0);
        #1;
        check_eq("post_ready0", {31'd0, O_req0_ready}, 32'd1);
        tick();
        I_req0_valid = 1'b0;
        tick(); #1;
        check_eq("post_resp_valid", {31'd0, O_resp0_valid}, 32'd1);
        check_eq("post_resp_data", O_resp0_data, 32'd5);
        tick(); #1;
        check_eq("post_idle", {31'd0, O_busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ceespu_alu_sched.md
# ceespu_alu_sched

Two-port scheduler that shares the single ceespu ALU between the core execute stage (port 0) and an auxiliary requester (port 1, coprocessor/debug). It arbitrates requests, holds ALU operands stable for the pipelined multiply, waits for the ALU's ready flag, and returns each result to the requester that issued it. One operation is in flight at a time. The block sits between both requesters and the ALU, and drives all ALU inputs.

## Interface
Parameters:
- none; widths are fixed: data 32, aluop 4.

Ports:
- I_clk  in  1  clock
- I_rst  in  1  reset, synchronous, active-high
- I_req0_valid / I_req1_valid  in  1  request valid per port
- I_req0_aluop / I_req1_aluop  in  4  ALU opcode (9 = multiply)
- I_req0_dataA, I_req0_dataB / I_req1_dataA, I_req1_dataB  in  32  operands
- I_req0_Cin / I_req1_Cin  in  1  carry-in
- O_req0_ready / O_req1_ready  out  1  request accepted when valid & ready
- O_resp0_valid / O_resp1_valid  out  1  result valid
- I_resp0_ready / I_resp1_ready  in  1  result consumed when valid & ready
- O_resp0_data / O_resp1_data  out  32  result
- O_resp0_Cout / O_resp1_Cout  out  1  carry-out
- O_alu_dataA, O_alu_dataB  out  32  to ALU
- O_alu_Cin  out  1  to ALU
- O_alu_aluop  out  4  to ALU
- I_alu_dataResult  in  32  from ALU
- I_alu_Cout  in  1  from ALU
- I_alu_dataReady  in  1  from ALU, multiply result valid
- O_busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, MUL_WAIT, RESP.
- IDLE:
  - O_reqN_ready is high only for the port the arbiter grants this cycle; it is combinational from the valids and the priority pointer.
  - On handshake: latch aluop, A, B, Cin and the port id into hold registers, then go to EXEC.
- EXEC:
  - ALU inputs are driven from the hold registers.
  - If aluop != 9: capture I_alu_dataResult and I_alu_Cout into the response register, then go to RESP.
  - If aluop == 9: go to MUL_WAIT.
- MUL_WAIT:
  - ALU inputs remain held from the hold registers.
  - When I_alu_dataReady is high: capture the result, force Cout to 0, then go to RESP.
- RESP:
  - O_respN_valid is high for the latched port only.
  - Data and Cout stay stable until I_respN_ready; then go to IDLE.
- Outside EXEC and MUL_WAIT: ALU inputs are driven to 0 (aluop 0 = add), so the ALU multi-cycle flag stays low.
- Arbitration:
  - If only one port is valid, that port is granted.
  - If both ports are valid, the port named by the priority pointer is granted.
  - After each grant, the pointer moves to the other port (see Configuration).
- Requesters must hold their request fields stable while valid is high and ready is low.
- Reset, including mid-operation:
  - State returns to IDLE and any in-flight result is dropped.
  - Pointer resets to 0.
  - Hold and response registers reset to 0.
  - All O_reqN_ready and O_respN_valid go low; O_busy goes low.
  - ALU outputs go to 0.

## Timing
- Handshake in cycle T puts the block in EXEC at T+1.
- Non-multiply: O_respN_valid rises at T+2.
- Multiply: the ALU asserts dataReady in the third cycle that multiCycle is high (T+3), so O_respN_valid rises at T+4.
  - If dataReady is later, the block waits in MUL_WAIT with no timeout.
- Response held with ready low: valid, data and Cout are unchanged each cycle.
- Response with ready high on the first RESP cycle: IDLE on the next cycle.
- The earliest next acceptance is the cycle after the response handshake.
- A request arriving during EXEC, MUL_WAIT or RESP sees ready low.
- Best case throughput is one operation per 3 cycles (non-multiply, zero-wait response).

## Configuration
- CEESPU_ALU_SCHED_RR_EN defined: round-robin arbitration; the pointer toggles to the non-granted port after every grant.
- Not defined: fixed priority, port 0 always wins; the pointer is constant 0.
  - Port 1 can starve; this is acceptable for debug-only use.

## Structure
- ceespu_pkg holds:
  - aluop constants: ADD=0, OR=1, AND=2, XOR=3, SEXT8=4, SEXT16=5, SHL=6, SHR=7, SAR=8, MUL=9
  - the FSM state enum
  - the port-id type
- Sub-module ceespu_rr_arb2: 2-way arbiter taking the valids and the pointer, producing a one-hot grant. The pointer update lives in the same sub-module and is compiled under the Configuration macro.

## Test plan
- Port 0 issues OR, A=0x0000F0F0, B=0x00000F0F -> O_resp0_valid at T+2, data 0x0000FFFF, Cout 0.
- Port 1 issues ADD, A=0xFFFFFFFF, B=0x00000001, Cin=0 -> data 0x00000000, Cout 1, port 0 response stays low.
- Port 0 issues MUL, A=7, B=6 -> ALU inputs held over T+1..T+3, resp at T+4, data 42; any port 1 request during this window sees ready low.
- Both ports valid every cycle with RR_EN -> grants alternate 0,1,0,1; without the macro -> port 0 granted every time.
- Response back-pressure: resp0_ready low for 5 cycles -> valid and data stable, no new grant; ready high -> IDLE the next cycle.
- I_rst asserted in MUL_WAIT -> next cycle IDLE, all valids and readies low, no response emitted; a fresh ADD afterwards completes normally.
